// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

   // Operation select; the encoding matches the external 2-bit mode port.
   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   // True for the two modes that move one serial bit into the word.
   function automatic logic is_shift(input mode_t m);
      return (m == MODE_SHR) || (m == MODE_SHL);
   endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register: synchronous-reset
// flip-flop fed by a 4:1 mux (hold / from MSB side / from LSB side / parallel).
module usr_bit_cell
   import usr_pkg::*;
(
   input  logic  Clk,
   input  logic  reset,
   input  mode_t mode,
   input  logic  from_msb,   // neighbour toward Q[WIDTH-1] (or SI_r at the top)
   input  logic  from_lsb,   // neighbour toward Q[0] (or SI_l at the bottom)
   input  logic  par,        // parallel load bit
   output logic  q
);

   logic next;

   // Select the next value of this bit from the requested operation.
   always_comb begin
      // NOTE: assigning a default before the case guarantees no latch is inferred.
      next = q;
      case (mode)
         MODE_HOLD: next = q;
         MODE_SHR:  next = from_msb;
         MODE_SHL:  next = from_lsb;
         MODE_LOAD: next = par;
         default:   next = q;
      endcase
   end

   // Storage flop; reset is synchronous and dominates every mode.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignment so all cells update together.
      if (reset) q <= 1'b0;
      else       q <= next;
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a shift counter that pulses frame_done
// once a full word has been shifted in serially.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] D_par,
   input  logic             SI_r,
   input  logic             SI_l,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qprime,
   output logic             SO_r,
   output logic             SO_l,
   output logic [CNT_W-1:0] shift_count,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

   mode_t            mode_e;
   logic [WIDTH-1:0] q_bits;

   assign mode_e = mode_t'(mode);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic from_msb;
      logic from_lsb;

      if (i == WIDTH - 1) begin : g_top
         assign from_msb = SI_r;
      end else begin : g_mid_hi
         assign from_msb = q_bits[i+1];
      end

      if (i == 0) begin : g_bot
         assign from_lsb = SI_l;
      end else begin : g_mid_lo
         assign from_lsb = q_bits[i-1];
      end

      usr_bit_cell u_cell (
         .Clk      (Clk),
         .reset    (reset),
         .mode     (mode_e),
         .from_msb (from_msb),
         .from_lsb (from_lsb),
         .par      (D_par[i]),
         .q        (q_bits[i])
      );
   end

   // Derived outputs are pure decodes of the registered word.
   assign Q      = q_bits;
   assign Qprime = ~q_bits;
   assign SO_r   = q_bits[0];
   assign SO_l   = q_bits[WIDTH-1];

   // Count shifts toward a frame; load clears, hold freezes, the WIDTH-th shift wraps and pulses.
   always_ff @(posedge Clk) begin
      if (reset) begin
         shift_count <= '0;
         frame_done  <= 1'b0;
      end else if (is_shift(mode_e)) begin
         if (shift_count == LAST_SHIFT) begin
            shift_count <= '0;
            frame_done  <= 1'b1;
         end else begin
            shift_count <= shift_count + 1'b1;
            frame_done  <= 1'b0;
         end
      end else begin
         frame_done <= 1'b0;
         if (mode_e == MODE_LOAD) shift_count <= '0;
      end
   end

endmodule
